// File: rtl/fp_mul_pkg.sv
// Shared parameters, state encoding and field widths for the FP multiplier significand stage.
package fp_mul_pkg;

  localparam int unsigned EXP_W_DEF  = 8;
  localparam int unsigned FRAC_W_DEF = 23;
  localparam int unsigned BIAS_DEF   = 127;

  // Derived field widths for the default format
  localparam int unsigned SIG_W_DEF  = FRAC_W_DEF + 1;
  localparam int unsigned WORD_W_DEF = 1 + EXP_W_DEF + FRAC_W_DEF;
  localparam int unsigned PROD_W_DEF = 2 * SIG_W_DEF;

  // FSM encoding
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_MULT = 2'b01;
  localparam logic [STATE_W-1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/fp_operand_classify.sv
// Unpacks one IEEE-754 operand and classifies it; exp==0 operands flush to zero.
module fp_operand_classify #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] op,
  output logic                  sign_c,
  output logic [EXP_W-1:0]      exp_c,
  output logic [FRAC_W:0]       sig_c,
  output logic                  is_zero_c,
  output logic                  is_inf_c,
  output logic                  is_nan_c
);

  logic [FRAC_W-1:0] frac;
  logic              exp_max;
  logic              exp_min;

  // Field extraction, hidden bit insertion and special-value decode
  always_comb begin
    sign_c    = op[EXP_W+FRAC_W];
    exp_c     = op[FRAC_W +: EXP_W];
    frac      = op[FRAC_W-1:0];
    exp_max   = &exp_c;
    exp_min   = (exp_c == '0);
    sig_c     = exp_min ? '0 : {1'b1, frac};
    is_zero_c = exp_min;
    is_inf_c  = exp_max && (frac == '0);
    is_nan_c  = exp_max && (frac != '0);
  end

endmodule

// File: rtl/fp_mul_significand_unit.sv
// FP multiplier front stage: sign/exponent sum, special flags, sequential radix-2 significand multiply.
module fp_mul_significand_unit
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  parameter int unsigned BIAS   = BIAS_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [EXP_W+FRAC_W:0]     a_in,
  input  logic [EXP_W+FRAC_W:0]     b_in,
  output logic                      ready,
  output logic                      done,
  output logic                      sign_out,
  output logic [EXP_W+1:0]          exp_sum,
  output logic [2*(FRAC_W+1)-1:0]   product,
  output logic                      MLB_significand_mult,
  output logic                      is_zero,
  output logic                      is_inf,
  output logic                      is_nan
);

  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned ES_W   = EXP_W + 2;
  localparam int unsigned CNT_W  = (SIG_W > 1) ? $clog2(SIG_W) : 1;

  // Operand decode
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

  fp_operand_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (
    .op        (a_in),
    .sign_c    (sign_a),
    .exp_c     (exp_a),
    .sig_c     (sig_a),
    .is_zero_c (zero_a),
    .is_inf_c  (inf_a),
    .is_nan_c  (nan_a)
  );

  fp_operand_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (
    .op        (b_in),
    .sign_c    (sign_b),
    .exp_c     (exp_b),
    .sig_c     (sig_b),
    .is_zero_c (zero_b),
    .is_inf_c  (inf_b),
    .is_nan_c  (nan_b)
  );

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PROD_W-1:0]  mcand_q;
  logic [SIG_W-1:0]   mplier_q;
  logic [PROD_W-1:0]  acc_q;

  // Results computed at acceptance, published when the product completes
  logic               sign_q;
  logic [ES_W-1:0]    exp_q;
  logic               zero_q, inf_q, nan_q;

  logic               last_step_c;
  logic [PROD_W-1:0]  acc_d_c;
  logic               nan_c, inf_c, zero_c;
  logic [ES_W-1:0]    exp_sum_c;

  // Shift-add step, sign/exponent arithmetic and flag priority (nan > inf > zero)
  always_comb begin
    last_step_c = (state_q == ST_MULT) && (cnt_q == CNT_W'(FRAC_W));
    acc_d_c     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    exp_sum_c   = ES_W'(exp_a) + ES_W'(exp_b) - ES_W'(BIAS);
    nan_c       = nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a);
    inf_c       = !nan_c && (inf_a || inf_b);
    zero_c      = !nan_c && !inf_c && (zero_a || zero_b);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_MULT;
      ST_MULT: if (last_step_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready                <= 1'b1;
      done                 <= 1'b0;
      sign_out             <= 1'b0;
      exp_sum              <= '0;
      product              <= '0;
      MLB_significand_mult <= 1'b0;
      is_zero              <= 1'b0;
      is_inf               <= 1'b0;
      is_nan               <= 1'b0;
      cnt_q                <= '0;
      mcand_q              <= '0;
      mplier_q             <= '0;
      acc_q                <= '0;
      sign_q               <= 1'b0;
      exp_q                <= '0;
      zero_q               <= 1'b0;
      inf_q                <= 1'b0;
      nan_q                <= 1'b0;
    end else begin
      ready <= (state_d == ST_IDLE);
      done  <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mcand_q              <= PROD_W'(sig_a);
            mplier_q             <= sig_b;
            acc_q                <= '0;
            cnt_q                <= '0;
            sign_q               <= sign_a ^ sign_b;
            exp_q                <= exp_sum_c;
            zero_q               <= zero_c;
            inf_q                <= inf_c;
            nan_q                <= nan_c;
            product              <= '0;
            MLB_significand_mult <= 1'b0;
            is_zero              <= 1'b0;
            is_inf               <= 1'b0;
            is_nan               <= 1'b0;
          end
        end
        ST_MULT: begin
          acc_q    <= acc_d_c;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_step_c) begin
            cnt_q                <= '0;
            product              <= acc_d_c;
            MLB_significand_mult <= acc_d_c[PROD_W-1];
            sign_out             <= sign_q;
            exp_sum              <= exp_q;
            is_zero              <= zero_q;
            is_inf               <= inf_q;
            is_nan               <= nan_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
